// File: rtl/key_debouncer.sv
// Input conditioning for the lock controller: two-flop synchronisers on the
// pushbutton and slide switches, plus a counter-qualified debounce FSM for the button.
module key_debouncer #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned DB_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n_raw,
  input  logic [17:0] SW_raw,
  output logic        action_n,
  output logic        press_pulse,
  output logic [17:0] SW,
  output logic        bouncing
);

  localparam int unsigned SW_W = 18;
  localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [DB_BITS-1:0] cnt, cnt_d;
  logic               action_n_d;
  logic               press_pulse_d;

  logic               key_q1, key_s;
  logic [SW_W-1:0]    sw_q1;

  // Synchronisers; key flops reset to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q1 <= 1'b1;
      key_s  <= 1'b1;
      sw_q1  <= '0;
      SW     <= '0;
    end else begin
      key_q1 <= key_n_raw;
      key_s  <= key_q1;
      sw_q1  <= SW_raw;
      SW     <= sw_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      action_n    <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      action_n    <= action_n_d;
      press_pulse <= press_pulse_d;
    end
  end

  // Any opposite sample during qualification drops back with no partial credit
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    action_n_d    = action_n;
    press_pulse_d = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d       = HELD;
          action_n_d    = 1'b0;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + DB_BITS'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d    = IDLE;
          action_n_d = 1'b1;
        end else begin
          cnt_d = cnt + DB_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bouncing = (state == PRESS_CHK) || (state == REL_CHK);

endmodule
